vending_core_param: RTL and testbench
=====================================

Name: vending_core_param

Overview:
Parametrised vending-machine controller, successor to the fixed 4-drink board controller. Accepts one-pulse coin, select and cancel strobes from the board's button and keyboard front end. Tracks credit and issues a dispense request with a ready/valid handshake. Returns change in timed steps driven by an external 1 Hz tick. Sits between the input front end (debounce/OnePulse/keyboard decoder) and the seven-segment/LED display logic.

Parameters:
N_DRINKS, 4, number of drink channels
N_COINS, 3, number of coin inputs
CREDIT_W, 7, credit register width
MAX_CREDIT, 100, credit saturation ceiling (must be < 2^CREDIT_W)
PRICES, {7'd80,7'd30,7'd25,7'd20}, packed N_DRINKS*CREDIT_W; price[i] = PRICES[i*CREDIT_W +: CREDIT_W] (drink0=20, drink3=80)
COIN_VALUES, {7'd50,7'd10,7'd5}, packed N_COINS*CREDIT_W; coin0=5, coin1=10, coin2=50
REFUND_STEP, 5, credit removed per refund tick

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
clr  in  1  synchronous soft clear
coin  in  N_COINS  one-cycle coin strobes
sel  in  N_DRINKS  one-cycle drink-select strobes
cancel  in  1  one-cycle refund request
tick  in  1  one-cycle 1 Hz pulse
tick_restart  out  1  one-cycle pulse telling the tick generator to restart its count
credit  out  CREDIT_W  current credit
available  out  N_DRINKS  affordable drinks mask
dispense_valid  out  1  dispense request
dispense_idx  out  $clog2(N_DRINKS)  drink being dispensed
dispense_ready  in  1  dispenser accepts the request
refunding  out  1  high while in REFUND
refund_pulse  out  1  one-cycle pulse for each REFUND_STEP returned

Behaviour:
- Reset and clr: credit=0, state=IDLE, all outputs 0. clr has priority over every other input, in any state.
- States: IDLE, DISPENSE, REFUND (registered). All outputs are registered except available.
- available[i] = (state==IDLE) && credit>=price[i]. The mask is 0 outside IDLE.
- IDLE input priority is cancel > sel > coin. Exactly one action per cycle.
  - cancel with credit>0: go to REFUND and pulse tick_restart for 1 cycle. cancel with credit==0 is ignored.
  - sel: take the lowest index i with sel[i] && available[i]. Then credit -= price[i], dispense_idx=i, dispense_valid=1 next cycle, go to DISPENSE. A sel on an unaffordable drink is ignored.
  - coin: take the lowest set index j; other simultaneous coins are dropped. credit = min(credit+value[j], MAX_CREDIT). Compute the sum at CREDIT_W+1 bits before saturating.
- DISPENSE:
  - dispense_valid and dispense_idx are held stable until the cycle where dispense_ready=1.
  - On that handshake cycle, drop dispense_valid next cycle. Go to REFUND (pulsing tick_restart) if credit>0, else go to IDLE.
  - coin, sel and cancel are ignored in this state.
- REFUND:
  - On each tick: credit = (credit>REFUND_STEP) ? credit-REFUND_STEP : 0, and refund_pulse fires 1 cycle.
  - When the updated credit is 0, go to IDLE.
  - A tick in the same cycle as entering REFUND is ignored.
  - coin, sel and cancel are ignored in this state.
- refunding=1 exactly while state==REFUND.
- Async rst mid-DISPENSE or mid-REFUND drops dispense_valid immediately; credit is lost.

Optional Feature:
Macro STOCK_TRACK_EN.
- When defined:
  - Adds a parameter STOCK_INIT (default 3, width 4) per drink.
  - Adds ports: restock (in, 1), which reloads every counter to STOCK_INIT; and sold_out (out, N_DRINKS), where sold_out[i] = (stock[i]==0).
  - available[i] is additionally gated by stock[i]!=0.
  - stock[i] decrements at sel acceptance.
  - Counters reset to STOCK_INIT on rst/clr.
  - restock is honoured in any state and takes effect before a same-cycle sel.
- When undefined: the ports and counters are absent and stock is unlimited.

Test Plan:
- Reset, then coin[1] x3 -> credit=30, available=4'b0111.
- credit=95, then coin[2] -> credit=100 (saturation). Then coin[0] and coin[2] in the same cycle -> credit stays 100, only coin[0] counted.
- credit=100, sel[3] -> credit=20, dispense_valid=1, dispense_idx=3. Hold dispense_ready=0 for 5 cycles -> outputs stable. Then dispense_ready=1 -> REFUND and tick_restart pulse. Then 4 ticks -> credit 15,10,5,0 with 4 refund_pulses, then IDLE.
- credit=25: sel=4'b1110 -> drink1 accepted, credit=0, no REFUND. Separately, cancel and sel[0] in the same cycle with credit=25 -> REFUND wins, credit unchanged.
- Mid-REFUND (credit=40): assert coin[2] and sel[0] -> ignored. Assert clr -> credit=0, IDLE, refunding=0.
- STOCK_TRACK_EN with STOCK_INIT=1: buy drink0 twice with credit=40 -> second sel ignored and sold_out[0]=1. Then restock -> sold_out=0.

Source files
------------

// File: rtl/vending_core_param_if.sv
// Dispense handshake between the vending controller and the dispenser.
// The master (controller) raises dispense_valid with a stable dispense_idx;
// the slave (dispenser) accepts with dispense_ready.
interface vending_core_param_if #(
    parameter int N_DRINKS = 4
);
    localparam int IDX_W = (N_DRINKS > 1) ? $clog2(N_DRINKS) : 1;

    logic             dispense_valid;
    logic [IDX_W-1:0] dispense_idx;
    logic             dispense_ready;

    modport master (
        output dispense_valid,
        output dispense_idx,
        input  dispense_ready
    );

    modport slave (
        input  dispense_valid,
        input  dispense_idx,
        output dispense_ready
    );
endinterface

// File: rtl/vending_core_param.sv
// Parametrised vending-machine controller: credit tracking, dispense
// handshake and timed change return driven by an external 1 Hz tick.
// Optional feature macro: STOCK_TRACK_EN adds per-drink stock counters,
// a restock input and a sold_out mask.
module vending_core_param #(
    parameter int                          N_DRINKS    = 4,
    parameter int                          N_COINS     = 3,
    parameter int                          CREDIT_W    = 7,
    parameter int                          MAX_CREDIT  = 100,
    parameter logic [N_DRINKS*CREDIT_W-1:0] PRICES     = {7'd80, 7'd30, 7'd25, 7'd20},
    parameter logic [N_COINS*CREDIT_W-1:0]  COIN_VALUES = {7'd50, 7'd10, 7'd5},
    parameter int                          REFUND_STEP = 5
`ifdef STOCK_TRACK_EN
    ,
    parameter logic [3:0]                  STOCK_INIT  = 4'd3
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic [N_COINS-1:0]  coin,
    input  logic [N_DRINKS-1:0] sel,
    input  logic                cancel,
    input  logic                tick,
    output logic                tick_restart,
    output logic [CREDIT_W-1:0] credit,
    output logic [N_DRINKS-1:0] available,
    output logic                refunding,
    output logic                refund_pulse,
`ifdef STOCK_TRACK_EN
    input  logic                restock,
    output logic [N_DRINKS-1:0] sold_out,
`endif
    vending_core_param_if.master disp
);
    localparam int IDX_W  = (N_DRINKS > 1) ? $clog2(N_DRINKS) : 1;
    localparam int CIDX_W = (N_COINS > 1) ? $clog2(N_COINS) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPENSE = 2'd1,
        S_REFUND   = 2'd2
    } state_t;

    state_t              r_state, w_state_next;
    logic [CREDIT_W-1:0] r_credit, w_credit_next;
    logic                r_valid, w_valid_next;
    logic [IDX_W-1:0]    r_idx, w_idx_next;
    logic                r_tick_restart, w_tick_restart_next;
    logic                r_refund_pulse, w_refund_pulse_next;

    logic [N_DRINKS-1:0][CREDIT_W-1:0] w_price;
    logic [N_COINS-1:0][CREDIT_W-1:0]  w_coin_val;
    logic [N_DRINKS-1:0]               w_avail;

    logic                w_sel_hit;
    logic [IDX_W-1:0]    w_sel_idx;
    logic                w_coin_hit;
    logic [CIDX_W-1:0]   w_coin_idx;
    logic [CREDIT_W:0]   w_coin_sum;
    logic [CREDIT_W-1:0] w_refund_credit;

`ifdef STOCK_TRACK_EN
    logic [N_DRINKS-1:0][3:0] r_stock, w_stock_next, w_stock_eff;
`endif

    // Unpack the price and coin tables; build the affordable-drink mask.
    // A same-cycle restock is folded into the stock seen by the mask so a
    // sel arriving with restock sees the refilled counters.
    genvar gi;
    generate
        for (gi = 0; gi < N_DRINKS; gi++) begin : g_drink
            assign w_price[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
`ifdef STOCK_TRACK_EN
            assign w_stock_eff[gi] = restock ? STOCK_INIT : r_stock[gi];
            assign w_avail[gi]     = (r_state == S_IDLE) && (r_credit >= w_price[gi])
                                     && (w_stock_eff[gi] != 4'd0);
            assign sold_out[gi]    = (r_stock[gi] == 4'd0);
`else
            assign w_avail[gi]     = (r_state == S_IDLE) && (r_credit >= w_price[gi]);
`endif
        end
        for (gi = 0; gi < N_COINS; gi++) begin : g_coin
            assign w_coin_val[gi] = COIN_VALUES[gi*CREDIT_W +: CREDIT_W];
        end
    endgenerate

    // Lowest-index affordable selection and lowest-index coin.
    always_comb begin
        w_sel_hit  = 1'b0;
        w_sel_idx  = '0;
        w_coin_hit = 1'b0;
        w_coin_idx = '0;
        for (int i = N_DRINKS - 1; i >= 0; i--) begin
            if (sel[i] && w_avail[i]) begin
                w_sel_hit = 1'b1;
                w_sel_idx = IDX_W'(i);
            end
        end
        for (int j = N_COINS - 1; j >= 0; j--) begin
            if (coin[j]) begin
                w_coin_hit = 1'b1;
                w_coin_idx = CIDX_W'(j);
            end
        end
    end

    // Credit arithmetic: one extra bit on the add so saturation sees overflow.
    assign w_coin_sum      = {1'b0, r_credit} + {1'b0, w_coin_val[w_coin_idx]};
    assign w_refund_credit = (r_credit > CREDIT_W'(REFUND_STEP))
                             ? (r_credit - CREDIT_W'(REFUND_STEP)) : '0;

    // Next-state and next-output logic; clr overrides everything.
    always_comb begin
        w_state_next        = r_state;
        w_credit_next       = r_credit;
        w_valid_next        = r_valid;
        w_idx_next          = r_idx;
        w_tick_restart_next = 1'b0;
        w_refund_pulse_next = 1'b0;
`ifdef STOCK_TRACK_EN
        w_stock_next        = w_stock_eff;
`endif
        if (clr) begin
            w_state_next  = S_IDLE;
            w_credit_next = '0;
            w_valid_next  = 1'b0;
            w_idx_next    = '0;
`ifdef STOCK_TRACK_EN
            w_stock_next  = {N_DRINKS{STOCK_INIT}};
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cancel && (r_credit != '0)) begin
                        w_state_next        = S_REFUND;
                        w_tick_restart_next = 1'b1;
                    end else if (w_sel_hit) begin
                        w_credit_next = r_credit - w_price[w_sel_idx];
                        w_idx_next    = w_sel_idx;
                        w_valid_next  = 1'b1;
                        w_state_next  = S_DISPENSE;
`ifdef STOCK_TRACK_EN
                        w_stock_next[w_sel_idx] = w_stock_eff[w_sel_idx] - 4'd1;
`endif
                    end else if (w_coin_hit) begin
                        if (w_coin_sum > (CREDIT_W + 1)'(MAX_CREDIT))
                            w_credit_next = CREDIT_W'(MAX_CREDIT);
                        else
                            w_credit_next = w_coin_sum[CREDIT_W-1:0];
                    end
                end
                S_DISPENSE: begin
                    if (disp.dispense_ready) begin
                        w_valid_next = 1'b0;
                        if (r_credit != '0) begin
                            w_state_next        = S_REFUND;
                            w_tick_restart_next = 1'b1;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end
                end
                S_REFUND: begin
                    if (tick) begin
                        w_credit_next       = w_refund_credit;
                        w_refund_pulse_next = 1'b1;
                        if (w_refund_credit == '0)
                            w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_valid_next = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; async reset loses credit and drops valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_credit       <= '0;
            r_valid        <= 1'b0;
            r_idx          <= '0;
            r_tick_restart <= 1'b0;
            r_refund_pulse <= 1'b0;
`ifdef STOCK_TRACK_EN
            r_stock        <= {N_DRINKS{STOCK_INIT}};
`endif
        end else begin
            r_state        <= w_state_next;
            r_credit       <= w_credit_next;
            r_valid        <= w_valid_next;
            r_idx          <= w_idx_next;
            r_tick_restart <= w_tick_restart_next;
            r_refund_pulse <= w_refund_pulse_next;
`ifdef STOCK_TRACK_EN
            r_stock        <= w_stock_next;
`endif
        end
    end

    assign credit              = r_credit;
    assign available           = w_avail;
    assign tick_restart        = r_tick_restart;
    assign refund_pulse        = r_refund_pulse;
    assign refunding           = (r_state == S_REFUND);
    assign disp.dispense_valid = r_valid;
    assign disp.dispense_idx   = r_idx;
endmodule

// File: tb/tb_vending_core_param.sv
// Directed testbench for vending_core_param (default prices/coins).
module tb_vending_core_param;
    logic       clk = 1'b0;
    logic       rst, clr, cancel, tick;
    logic [2:0] coin;
    logic [3:0] sel;
    logic       tick_restart, refunding, refund_pulse;
    logic [6:0] credit;
    logic [3:0] available;
`ifdef STOCK_TRACK_EN
    logic       restock;
    logic [3:0] sold_out;
`endif

    int n_vec = 0;
    int n_err = 0;

    vending_core_param_if #(.N_DRINKS(4)) disp_if ();

    vending_core_param #(
`ifdef STOCK_TRACK_EN
        .STOCK_INIT(4'd1),
`endif
        .N_DRINKS(4)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .coin(coin), .sel(sel),
        .cancel(cancel), .tick(tick), .tick_restart(tick_restart),
        .credit(credit), .available(available), .refunding(refunding),
        .refund_pulse(refund_pulse),
`ifdef STOCK_TRACK_EN
        .restock(restock), .sold_out(sold_out),
`endif
        .disp(disp_if)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle 1 ns past the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input int j);
        coin = 3'b000;
        coin[j] = 1'b1;
        cyc();
        coin = 3'b000;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cyc();
        n_vec++;
        if (credit !== 7'd0 || disp_if.dispense_valid !== 1'b0 || refunding !== 1'b0 ||
            tick_restart !== 1'b0 || refund_pulse !== 1'b0 || available !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_state: credit=%0d valid=%b refunding=%b tr=%b rp=%b avail=%b, required all 0",
                     credit, disp_if.dispense_valid, refunding, tick_restart, refund_pulse, available);
        end
        rst = 1'b0;
        cyc();
        n_vec++;
        if (credit !== 7'd0 || available !== 4'b0000) begin
            n_err++;
            $display("FAIL post_reset: credit=%0d avail=%b, required 0/0000", credit, available);
        end
        $display("test_reset done");
    endtask

    task automatic test_coin();
        for (int k = 1; k <= 3; k++) begin
            put_coin(1);
            n_vec++;
            if (credit !== 7'(10 * k)) begin
                n_err++;
                $display("FAIL coin1_step%0d: credit=%0d required %0d", k, credit, 10 * k);
            end
        end
        n_vec++;
        if (available !== 4'b0111) begin
            n_err++;
            $display("FAIL avail_30: got %b required 0111", available);
        end
        $display("test_coin done: credit=%0d", credit);
    endtask

    task automatic test_saturation();
        do_clr();
        coin = 3'b110;
        cyc();
        coin = 3'b000;
        n_vec++;
        if (credit !== 7'd10) begin
            n_err++;
            $display("FAIL multi_coin_lowest: credit=%0d required 10", credit);
        end
        do_clr();
        put_coin(2);
        for (int k = 0; k < 4; k++) put_coin(1);
        put_coin(0);
        n_vec++;
        if (credit !== 7'd95) begin
            n_err++;
            $display("FAIL build_95: credit=%0d required 95", credit);
        end
        put_coin(2);
        n_vec++;
        if (credit !== 7'd100) begin
            n_err++;
            $display("FAIL saturate_100: credit=%0d required 100", credit);
        end
        coin = 3'b101;
        cyc();
        coin = 3'b000;
        n_vec++;
        if (credit !== 7'd100 || available !== 4'b1111) begin
            n_err++;
            $display("FAIL saturate_hold: credit=%0d avail=%b required 100/1111", credit, available);
        end
        $display("test_saturation done: credit=%0d", credit);
    endtask

    task automatic test_dispense_handshake();
        sel = 4'b1000;
        cyc();
        sel = 4'b0000;
        n_vec++;
        if (credit !== 7'd20 || disp_if.dispense_valid !== 1'b1 || disp_if.dispense_idx !== 2'd3 ||
            available !== 4'b0000 || refunding !== 1'b0) begin
            n_err++;
            $display("FAIL sel3_accept: credit=%0d valid=%b idx=%0d avail=%b ref=%b required 20/1/3/0000/0",
                     credit, disp_if.dispense_valid, disp_if.dispense_idx, available, refunding);
        end
        // Held off by dispenser; strobes in DISPENSE must be ignored.
        for (int k = 0; k < 5; k++) begin
            coin = 3'b100; sel = 4'b0001; cancel = 1'b1;
            cyc();
            coin = 3'b000; sel = 4'b0000; cancel = 1'b0;
            n_vec++;
            if (credit !== 7'd20 || disp_if.dispense_valid !== 1'b1 || disp_if.dispense_idx !== 2'd3) begin
                n_err++;
                $display("FAIL hold_stable%0d: credit=%0d valid=%b idx=%0d required 20/1/3",
                         k, credit, disp_if.dispense_valid, disp_if.dispense_idx);
            end
        end
        // Handshake; a tick in the entry cycle must not refund.
        disp_if.dispense_ready = 1'b1; tick = 1'b1;
        cyc();
        disp_if.dispense_ready = 1'b0; tick = 1'b0;
        n_vec++;
        if (disp_if.dispense_valid !== 1'b0 || refunding !== 1'b1 || tick_restart !== 1'b1 ||
            credit !== 7'd20 || refund_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL handshake: valid=%b ref=%b tr=%b credit=%0d rp=%b required 0/1/1/20/0",
                     disp_if.dispense_valid, refunding, tick_restart, credit, refund_pulse);
        end
        cyc();
        n_vec++;
        if (tick_restart !== 1'b0) begin
            n_err++;
            $display("FAIL tick_restart_1cyc: got %b required 0", tick_restart);
        end
        for (int k = 1; k <= 4; k++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            n_vec++;
            if (credit !== 7'(20 - 5 * k) || refund_pulse !== 1'b1 || refunding !== (k < 4)) begin
                n_err++;
                $display("FAIL refund_tick%0d: credit=%0d rp=%b ref=%b required %0d/1/%0d",
                         k, credit, refund_pulse, refunding, 20 - 5 * k, (k < 4));
            end
            cyc();
            n_vec++;
            if (refund_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL refund_pulse_drop%0d: got %b required 0", k, refund_pulse);
            end
        end
        $display("test_dispense_handshake done");
    endtask

    task automatic test_sel_priority();
        put_coin(1); put_coin(1); put_coin(0);
        sel = 4'b1110;
        cyc();
        sel = 4'b0000;
        n_vec++;
        if (disp_if.dispense_valid !== 1'b1 || disp_if.dispense_idx !== 2'd1 || credit !== 7'd0) begin
            n_err++;
            $display("FAIL sel_lowest_affordable: valid=%b idx=%0d credit=%0d required 1/1/0",
                     disp_if.dispense_valid, disp_if.dispense_idx, credit);
        end
        disp_if.dispense_ready = 1'b1;
        cyc();
        disp_if.dispense_ready = 1'b0;
        n_vec++;
        if (disp_if.dispense_valid !== 1'b0 || refunding !== 1'b0 || tick_restart !== 1'b0) begin
            n_err++;
            $display("FAIL no_refund_at_zero: valid=%b ref=%b tr=%b required 0/0/0",
                     disp_if.dispense_valid, refunding, tick_restart);
        end
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        n_vec++;
        if (refunding !== 1'b0 || tick_restart !== 1'b0) begin
            n_err++;
            $display("FAIL cancel_zero_ignored: ref=%b tr=%b required 0/0", refunding, tick_restart);
        end
        put_coin(1); put_coin(1); put_coin(0);
        cancel = 1'b1; sel = 4'b0001;
        cyc();
        cancel = 1'b0; sel = 4'b0000;
        n_vec++;
        if (refunding !== 1'b1 || credit !== 7'd25 || disp_if.dispense_valid !== 1'b0 || tick_restart !== 1'b1) begin
            n_err++;
            $display("FAIL cancel_beats_sel: ref=%b credit=%0d valid=%b tr=%b required 1/25/0/1",
                     refunding, credit, disp_if.dispense_valid, tick_restart);
        end
        do_clr();
        $display("test_sel_priority done");
    endtask

    task automatic test_refund_ignore();
        for (int k = 0; k < 4; k++) put_coin(1);
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        cyc();
        coin = 3'b100; sel = 4'b0001;
        cyc();
        coin = 3'b000; sel = 4'b0000;
        n_vec++;
        if (credit !== 7'd40 || refunding !== 1'b1 || disp_if.dispense_valid !== 1'b0) begin
            n_err++;
            $display("FAIL refund_ignores_inputs: credit=%0d ref=%b valid=%b required 40/1/0",
                     credit, refunding, disp_if.dispense_valid);
        end
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        n_vec++;
        if (credit !== 7'd35 || refund_pulse !== 1'b1) begin
            n_err++;
            $display("FAIL refund_step_40: credit=%0d rp=%b required 35/1", credit, refund_pulse);
        end
        clr = 1'b1; tick = 1'b1;
        cyc();
        clr = 1'b0; tick = 1'b0;
        n_vec++;
        if (credit !== 7'd0 || refunding !== 1'b0 || refund_pulse !== 1'b0 || available !== 4'b0000) begin
            n_err++;
            $display("FAIL clr_in_refund: credit=%0d ref=%b rp=%b avail=%b required 0/0/0/0000",
                     credit, refunding, refund_pulse, available);
        end
        $display("test_refund_ignore done");
    endtask

    task automatic test_async_reset();
        put_coin(2);
        sel = 4'b0001;
        cyc();
        sel = 4'b0000;
        n_vec++;
        if (disp_if.dispense_valid !== 1'b1 || credit !== 7'd30) begin
            n_err++;
            $display("FAIL pre_async: valid=%b credit=%0d required 1/30", disp_if.dispense_valid, credit);
        end
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if (disp_if.dispense_valid !== 1'b0 || credit !== 7'd0) begin
            n_err++;
            $display("FAIL async_reset: valid=%b credit=%0d required 0/0", disp_if.dispense_valid, credit);
        end
        cyc();
        rst = 1'b0;
        cyc();
        $display("test_async_reset done");
    endtask

`ifdef STOCK_TRACK_EN
    task automatic test_stock();
        do_clr();
        n_vec++;
        if (sold_out !== 4'b0000) begin
            n_err++;
            $display("FAIL stock_init: sold_out=%b required 0000", sold_out);
        end
        for (int k = 0; k < 4; k++) put_coin(1);
        sel = 4'b0001;
        cyc();
        sel = 4'b0000;
        n_vec++;
        if (credit !== 7'd20 || disp_if.dispense_valid !== 1'b1 || sold_out !== 4'b0001) begin
            n_err++;
            $display("FAIL stock_buy1: credit=%0d valid=%b sold_out=%b required 20/1/0001",
                     credit, disp_if.dispense_valid, sold_out);
        end
        disp_if.dispense_ready = 1'b1;
        cyc();
        disp_if.dispense_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick = 1'b1; cyc(); tick = 1'b0; cyc();
        end
        put_coin(1); put_coin(1);
        sel = 4'b0001;
        cyc();
        sel = 4'b0000;
        n_vec++;
        if (credit !== 7'd20 || disp_if.dispense_valid !== 1'b0 || available !== 4'b0000) begin
            n_err++;
            $display("FAIL stock_buy2_ignored: credit=%0d valid=%b avail=%b required 20/0/0000",
                     credit, disp_if.dispense_valid, available);
        end
        restock = 1'b1; sel = 4'b0001;
        cyc();
        restock = 1'b0; sel = 4'b0000;
        n_vec++;
        if (credit !== 7'd0 || disp_if.dispense_valid !== 1'b1 || sold_out !== 4'b0001) begin
            n_err++;
            $display("FAIL restock_with_sel: credit=%0d valid=%b sold_out=%b required 0/1/0001",
                     credit, disp_if.dispense_valid, sold_out);
        end
        restock = 1'b1;
        cyc();
        restock = 1'b0;
        n_vec++;
        if (sold_out !== 4'b0000) begin
            n_err++;
            $display("FAIL restock: sold_out=%b required 0000", sold_out);
        end
        disp_if.dispense_ready = 1'b1;
        cyc();
        disp_if.dispense_ready = 1'b0;
        $display("test_stock done");
    endtask
`endif

    initial begin
        rst = 1'b1; clr = 1'b0; cancel = 1'b0; tick = 1'b0;
        coin = 3'b000; sel = 4'b0000;
        disp_if.dispense_ready = 1'b0;
`ifdef STOCK_TRACK_EN
        restock = 1'b0;
`endif
        #1;
        test_reset();
        test_coin();
        test_saturation();
        test_dispense_handshake();
        test_sel_priority();
        test_refund_ignore();
        test_async_reset();
`ifdef STOCK_TRACK_EN
        test_stock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
